i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter SAMPLE_W, default 16: bits per channel sample.
REQ-002 Parameter BCLK_DIV, default 2, minimum 1: clk cycles per bclk half-period.
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sample_l  input  SAMPLE_W  left-channel sample, two's complement.
REQ-006 sample_r  input  SAMPLE_W  right-channel sample, two's complement.
REQ-007 sample_valid  input  1  producer has a stereo pair on sample_l/sample_r.
REQ-008 sample_ready  output  1  holding register empty; a pair can be accepted.
REQ-009 bclk  output  1  I2S bit clock.
REQ-010 lrclk  output  1  I2S word select; 0 = left, 1 = right.
REQ-011 sdata  output  1  I2S serial data, MSB first.
REQ-012 underrun  output  1  one-clk pulse when a frame starts with no pair held.

Function
REQ-013 Divider counter runs 0..BCLK_DIV-1 and wraps; bclk SHALL toggle on each wrap, giving a bclk period of 2*BCLK_DIV clk.
REQ-014 A frame is 2*SAMPLE_W bclk periods; bit index b (0..2*SAMPLE_W-1) SHALL advance on each bclk falling edge and wrap to 0.
REQ-015 lrclk SHALL be 0 for b < SAMPLE_W and 1 otherwise, changing on the bclk falling edge.
REQ-016 One-bit I2S delay: left MSB..LSB on b=1..SAMPLE_W; right MSB..LSB on b=SAMPLE_W+1..2*SAMPLE_W-1, then right LSB on b=0 of the next frame.
REQ-017 sdata and lrclk SHALL change only on bclk falling edges; they hold stable across every rising edge.
REQ-018 The handshake completes on a clk edge where sample_valid && sample_ready; the pair is captured into the holding register.
REQ-019 After capture, sample_ready SHALL be 0 on the next cycle.
REQ-020 The holding register holds exactly one pair.
REQ-021 At the bclk falling edge entering b=1, if the holding register is full, its pair SHALL load into the shift register, the holding register SHALL empty, and sample_ready SHALL be 1 on the next cycle.
REQ-022 At the same edge, if the holding register is empty, the shift register SHALL load all zeros and underrun SHALL pulse high for exactly one clk.
REQ-023 If a handshake and a frame load fall on the same clk edge, the load SHALL take the previously held pair and the new pair SHALL be captured, leaving the holding register full.
REQ-024 While sample_ready is 0, sample_valid SHALL be ignored; the producer holds its data.
REQ-025 Samples SHALL be transmitted bit-exact; no rounding or sign extension.

Reset
REQ-026 While rst=1, on every clk edge:
- bclk=0, lrclk=0, sdata=0, underrun=0, sample_ready=1;
- divider=0, b=0;
- holding register empty, shift register zero.
REQ-027 Reset asserted mid-frame SHALL abort the frame.
REQ-028 After rst deasserts, the first bclk rising edge SHALL occur BCLK_DIV clk later.
REQ-029 After reset, the first frame starts at b=0 with lrclk=0.

Structure
REQ-030 Package audio_pkg SHALL hold SAMPLE_W default, the sample_t typedef (signed, SAMPLE_W bits) and the stereo_t struct {sample_t l, r}.
REQ-031 One sub-module, i2s_bclk_gen, SHALL produce bclk plus one-clk fall_strobe/rise_strobe pulses from the divider.
REQ-032 The frame state SHALL be a bit counter plus a 2*SAMPLE_W shift register with a one-bit output delay stage; no separate FSM.

Verification
REQ-033 rst released, L=16'hA5A5, R=16'h5A5A presented before the first frame -> frame 1 decodes L=A5A5, R=5A5A; lrclk low for 16 bclk, high for 16; underrun never pulses.
REQ-034 No sample_valid after reset -> sdata all zeros; underrun pulses once per frame, every 128 clk (BCLK_DIV=2).
REQ-035 sample_valid held high with an incrementing pair (L=n, R=~n) -> exactly one pair accepted per frame; decoded sequence has no gaps or repeats.
REQ-036 Handshake on the same edge as the b=1 load (L=16'h8000, R=16'h7FFF) -> the older pair is transmitted first, the new pair next frame, and sample_ready stays 0 until the following load.
REQ-037 rst pulsed for 1 clk at b=10 of a frame -> outputs match REQ-026 the next cycle; a pair offered after reset appears intact in the first new frame.
REQ-038 BCLK_DIV=1 and BCLK_DIV=5 -> bclk periods of 2 and 10 clk; sdata never changes within one clk of a bclk rising edge.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample width and stereo sample types for the audio path
package audio_pkg;
   localparam int SAMPLE_W_DEF = 16;
   typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;
   typedef struct packed {
      sample_t l;
      sample_t r;
   } stereo_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into bclk and flags the clk edge on which bclk will rise or fall
module i2s_bclk_gen #(
   parameter int BCLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic bclk,
   output logic fall_strobe,
   output logic rise_strobe
);
   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   logic [DIV_W-1:0] r_div;
   logic             r_bclk;
   logic             w_wrap;
   assign w_wrap      = r_div == DIV_W'(BCLK_DIV - 1);
   assign fall_strobe = w_wrap & r_bclk;
   assign rise_strobe = w_wrap & ~r_bclk;
   assign bclk        = r_bclk;
   // divider runs 0..BCLK_DIV-1 and bclk flips on every wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
      end else begin
         r_div  <= w_wrap ? '0 : r_div + 1'b1;
         r_bclk <= r_bclk ^ w_wrap;
      end
   end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: single-pair buffered I2S transmitter with one-bit data delay after word select
module i2s_tx
   import audio_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int BCLK_DIV = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [SAMPLE_W-1:0] sample_l,
   input  logic signed [SAMPLE_W-1:0] sample_r,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   output logic                       bclk,
   output logic                       lrclk,
   output logic                       sdata,
   output logic                       underrun
);
   localparam int FRAME_BITS = 2 * SAMPLE_W;
   localparam int BIT_W      = $clog2(FRAME_BITS);
   logic [BIT_W-1:0]      r_bit;
   logic [FRAME_BITS-1:0] r_hold;
   logic [FRAME_BITS-1:0] r_shift;
   logic                  r_full;
   logic                  r_lrclk;
   logic                  r_sdata;
   logic                  r_underrun;
   logic                  w_fall;
   logic                  w_rise;
   logic                  w_load;
   logic                  w_take;
   logic [BIT_W-1:0]      w_next_bit;
   logic [FRAME_BITS-1:0] w_word;
   i2s_bclk_gen #(
      .BCLK_DIV(BCLK_DIV)
   ) u_bclk_gen (
      .clk        (clk),
      .rst        (rst),
      .bclk       (bclk),
      .fall_strobe(w_fall),
      .rise_strobe(w_rise)
   );
   assign w_next_bit   = (r_bit == BIT_W'(FRAME_BITS - 1)) ? '0 : r_bit + 1'b1;
   assign w_load       = w_fall & (r_bit == '0);
   assign w_word       = r_full ? r_hold : '0;
   // the load edge frees the holding slot, so a pair can be taken on that same edge
   assign sample_ready = ~r_full | w_load;
   assign w_take       = sample_valid & sample_ready;
   assign lrclk        = r_lrclk;
   assign sdata        = r_sdata;
   assign underrun     = r_underrun;
   // one-pair holding register: filled by the handshake, drained by the frame load
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full <= 1'b0;
         r_hold <= '0;
      end else begin
         r_full <= w_take | (r_full & ~w_load);
         r_hold <= w_take ? {sample_l, sample_r} : r_hold;
      end
   end
   // frame engine: bit index and outputs move on bclk falls, shifter pre-advances on rises
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit      <= '0;
         r_shift    <= '0;
         r_lrclk    <= 1'b0;
         r_sdata    <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= w_load & ~r_full;
         if (w_fall) begin
            r_bit   <= w_next_bit;
            r_lrclk <= w_next_bit >= BIT_W'(SAMPLE_W);
            r_sdata <= w_load ? w_word[FRAME_BITS-1] : r_shift[FRAME_BITS-1];
         end
         if (w_load)
            r_shift <= w_word;
         else if (w_rise)
            r_shift <= r_shift << 1;
      end
   end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench decoding the I2S stream of i2s_tx and checking bclk timing
module tb_i2s_tx;
   localparam int W     = 16;
   localparam int DIV   = 2;
   localparam int FRAME = 4 * W * DIV;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] sample_l = '0;
   logic [W-1:0] sample_r = '0;
   logic         sample_valid = 1'b0;
   logic         sample_ready, bclk, lrclk, sdata, underrun;
   logic [1:0]   a_ready, a_bclk, a_lr, a_sd, a_un;
   int           n_chk = 0;
   int           n_pass = 0;
   always #5 clk = ~clk;
   i2s_tx #(.SAMPLE_W(W), .BCLK_DIV(DIV)) u_dut (
      .clk(clk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
   );
   i2s_tx #(.SAMPLE_W(W), .BCLK_DIV(1)) u_d1 (
      .clk(clk), .rst(rst), .sample_l(16'h9C31), .sample_r(16'h0F5A),
      .sample_valid(1'b1), .sample_ready(a_ready[0]),
      .bclk(a_bclk[0]), .lrclk(a_lr[0]), .sdata(a_sd[0]), .underrun(a_un[0])
   );
   i2s_tx #(.SAMPLE_W(W), .BCLK_DIV(5)) u_d5 (
      .clk(clk), .rst(rst), .sample_l(16'h9C31), .sample_r(16'h0F5A),
      .sample_valid(1'b1), .sample_ready(a_ready[1]),
      .bclk(a_bclk[1]), .lrclk(a_lr[1]), .sdata(a_sd[1]), .underrun(a_un[1])
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // reference model: frame loads at fixed clk offsets after reset, one-pair holding slot
   int             m_cyc;
   logic           m_full, m_under, m_ld, m_rdy, m_hs;
   logic [2*W-1:0] m_hold;
   logic [2*W-1:0] exp_q[$];
   assign m_ld  = !rst && ((m_cyc % FRAME) == 2 * DIV - 1);
   assign m_rdy = !m_full || m_ld;
   assign m_hs  = sample_valid && m_rdy;
   always @(posedge clk) begin
      if (rst) begin
         m_cyc   <= 0;
         m_full  <= 1'b0;
         m_under <= 1'b0;
         exp_q.delete();
      end else begin
         if (m_ld) exp_q.push_back(m_full ? m_hold : '0);
         m_under <= m_ld && !m_full;
         m_full  <= m_hs || (m_full && !m_ld);
         if (m_hs) m_hold <= {sample_l, sample_r};
         m_cyc   <= m_cyc + 1;
      end
   end
   // handshake and underrun follow the model every cycle
   always @(negedge clk) begin
      chk("sample_ready", sample_ready, m_rdy);
      chk("underrun", underrun, m_under);
   end
   // I2S decoder on the main DUT: bits sampled on bclk rises, word closes on lrclk change
   logic         d_pbk, d_lr;
   int           d_cnt;
   logic [W-1:0] d_sr, d_l;
   always @(negedge clk) begin
      if (rst) begin
         d_lr  <= 1'b0;
         d_cnt <= 0;
         d_sr  <= '0;
      end else if (bclk && !d_pbk) begin
         if (lrclk != d_lr) begin
            chk("lrclk_phase_len", d_cnt, W);
            if (!d_lr) d_l <= {d_sr[W-2:0], sdata};
            else if (exp_q.size() == 0) chk("scoreboard_has_frame", exp_q.size(), 1);
            else begin
               chk("left_word", d_l, exp_q[0][2*W-1:W]);
               chk("right_word", {d_sr[W-2:0], sdata}, exp_q[0][W-1:0]);
               exp_q.delete(0);
            end
            d_lr  <= lrclk;
            d_cnt <= 1;
            d_sr  <= '0;
         end else begin
            d_cnt <= d_cnt + 1;
            d_sr  <= {d_sr[W-2:0], sdata};
         end
      end
      d_pbk <= bclk;
   end
   // bclk period, first-rise latency and data stability for all three dividers
   logic [2:0] bk, sd, lr, p_bk, p_sd, p_lr, p_seen;
   int         p_cnt[3];
   int         divs[3] = '{DIV, 1, 5};
   assign bk = {a_bclk[1], a_bclk[0], bclk};
   assign sd = {a_sd[1], a_sd[0], sdata};
   assign lr = {a_lr[1], a_lr[0], lrclk};
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            p_cnt[i]  <= 0;
            p_seen[i] <= 1'b0;
         end else if (bk[i] && !p_bk[i]) begin
            chk($sformatf("sdata_stable_div%0d", divs[i]), sd[i], p_sd[i]);
            chk($sformatf("lrclk_stable_div%0d", divs[i]), lr[i], p_lr[i]);
            if (p_seen[i]) chk($sformatf("bclk_period_div%0d", divs[i]), p_cnt[i] + 1, 2 * divs[i]);
            else chk($sformatf("first_rise_div%0d", divs[i]), p_cnt[i], divs[i]);
            p_cnt[i]  <= 0;
            p_seen[i] <= 1'b1;
         end else p_cnt[i] <= p_cnt[i] + 1;
      end
      p_bk <= bk;
      p_sd <= sd;
      p_lr <= lr;
   end
   task automatic reset_outputs(input string tag);
      chk({tag, "_bclk"}, bclk, 0);
      chk({tag, "_lrclk"}, lrclk, 0);
      chk({tag, "_sdata"}, sdata, 0);
      chk({tag, "_underrun"}, underrun, 0);
      chk({tag, "_ready"}, sample_ready, 1);
   endtask
   task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
      int n = 0;
      sample_l     = l;
      sample_r     = r;
      sample_valid = 1'b1;
      @(negedge clk);
      while (!sample_ready && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      chk("send_accepted", sample_ready, 1);
      @(posedge clk);
      #1;
   endtask
   task automatic wait_phase(input int ph);
      int n = 0;
      @(negedge clk);
      while ((m_cyc % FRAME) != ph && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      chk("phase_reached", m_cyc % FRAME, ph);
   endtask
   initial begin
      int nu;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      send(16'hA5A5, 16'h5A5A);
      for (int n = 1; n <= 4; n++) send(W'(n), ~W'(n));
      send(16'h8000, 16'h7FFF);
      @(negedge clk);
      chk("ready_after_coincident", sample_ready, 0);
      sample_valid = 1'b0;
      wait_phase(10);
      wait_phase(10);
      for (int f = 0; f < 2; f++) begin
         nu = 0;
         repeat (FRAME) begin
            @(negedge clk);
            nu += int'(underrun);
         end
         chk("underrun_per_frame", nu, 1);
      end
      send(16'h1234, 16'hFEDC);
      sample_valid = 1'b0;
      wait_phase(5);
      wait_phase(40);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      reset_outputs("midframe_reset");
      send(16'hCAFE, 16'h0BAD);
      sample_valid = 1'b0;
      wait_phase(64);
      wait_phase(64);
      chk("frames_pending", exp_q.size(), 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
